// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory,
// and drives the IF/ID register. Branch/jump redirects from decode follow
// MIPS delay-slot semantics; a one-entry skid buffer absorbs a fetch that
// completes while decode is stalled so no instruction is lost or duplicated.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_id_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        next_inst_in_delayslot_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        is_in_delayslot_o
);

  logic [31:0] pc_reg, pc_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [31:0] buf_pc_reg, buf_pc_next;
  logic [31:0] buf_inst_reg, buf_inst_next;
  logic        redir_pending_reg, redir_pending_next;
  logic [31:0] redir_target_reg, redir_target_next;
  logic        ds_pending_reg, ds_pending_next;
  logic [31:0] id_pc_reg, id_pc_next;
  logic [31:0] id_inst_reg, id_inst_next;
  logic        id_ds_reg, id_ds_next;

  logic fetch_done;
  logic branch_accept;
  logic ds_flag;
  logic load_real;

  // No request while the skid buffer is full; the address is simply the PC.
  assign imem_req_o  = !rst && !buf_valid_reg;
  assign imem_addr_o = pc_reg;

  assign fetch_done    = imem_req_o && imem_ack_i;
  assign branch_accept = branch_flag_i && !stall_id_i;
  // A delay-slot marker raised this cycle applies to an instruction loaded this cycle.
  assign ds_flag       = ds_pending_reg || (next_inst_in_delayslot_i && !stall_id_i);
  assign load_real     = !stall_id_i && (buf_valid_reg || fetch_done);

  assign id_pc_o           = id_pc_reg;
  assign id_inst_o         = id_inst_reg;
  assign is_in_delayslot_o = id_ds_reg;

  // Next-state logic for PC, skid buffer, redirect, delay-slot tracking and IF/ID.
  always_comb begin
    pc_next            = pc_reg;
    buf_valid_next     = buf_valid_reg;
    buf_pc_next        = buf_pc_reg;
    buf_inst_next      = buf_inst_reg;
    redir_pending_next = redir_pending_reg;
    redir_target_next  = redir_target_reg;
    ds_pending_next    = ds_pending_reg;
    id_pc_next         = id_pc_reg;
    id_inst_next       = id_inst_reg;
    id_ds_next         = id_ds_reg;

    // IF/ID: buffered instruction first, then a completing fetch, else a bubble.
    if (!stall_id_i) begin
      if (buf_valid_reg) begin
        id_pc_next   = buf_pc_reg;
        id_inst_next = buf_inst_reg;
        id_ds_next   = ds_flag;
      end else if (fetch_done) begin
        id_pc_next   = pc_reg;
        id_inst_next = imem_data_i;
        id_ds_next   = ds_flag;
      end else begin
        id_pc_next   = 32'h0;
        id_inst_next = 32'h0;
        id_ds_next   = 1'b0;
      end
    end

    // Skid buffer catches a fetch that lands while decode is frozen.
    if (stall_id_i && fetch_done) begin
      buf_valid_next = 1'b1;
      buf_pc_next    = pc_reg;
      buf_inst_next  = imem_data_i;
    end else if (!stall_id_i) begin
      buf_valid_next = 1'b0;
    end

    // Bubbles leave the pending delay-slot marker in place for the next real instruction.
    ds_pending_next = load_real ? 1'b0 : ds_flag;

    // PC: if the delay slot is already in hand, jump now; otherwise defer
    // the redirect until the delay-slot fetch completes.
    if (branch_accept && (buf_valid_reg || fetch_done)) begin
      pc_next = branch_target_address_i;
    end else if (branch_accept) begin
      redir_pending_next = 1'b1;
      redir_target_next  = branch_target_address_i;
    end else if (fetch_done) begin
      pc_next            = redir_pending_reg ? redir_target_reg : (pc_reg + 32'd4);
      redir_pending_next = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg            <= RESET_PC;
      buf_valid_reg     <= 1'b0;
      buf_pc_reg        <= 32'h0;
      buf_inst_reg      <= 32'h0;
      redir_pending_reg <= 1'b0;
      redir_target_reg  <= 32'h0;
      ds_pending_reg    <= 1'b0;
      id_pc_reg         <= 32'h0;
      id_inst_reg       <= 32'h0;
      id_ds_reg         <= 1'b0;
    end else begin
      pc_reg            <= pc_next;
      buf_valid_reg     <= buf_valid_next;
      buf_pc_reg        <= buf_pc_next;
      buf_inst_reg      <= buf_inst_next;
      redir_pending_reg <= redir_pending_next;
      redir_target_reg  <= redir_target_next;
      ds_pending_reg    <= ds_pending_next;
      id_pc_reg         <= id_pc_next;
      id_inst_reg       <= id_inst_next;
      id_ds_reg         <= id_ds_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: randomized memory latency, decode stalls and
// branches; expected program-order instruction stream kept in a scoreboard.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        next_inst_in_delayslot_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        is_in_delayslot_o;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .stall_id_i(stall_id_i),
    .branch_flag_i(branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .next_inst_in_delayslot_i(next_inst_in_delayslot_i),
    .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i),
    .imem_data_i(imem_data_i),
    .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o),
    .is_in_delayslot_o(is_in_delayslot_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // stimulus configuration
  int lat_min, lat_max, stall_pct, br_pct;
  bit fixed_timing;

  // model view of the instruction currently in decode
  bit          cur_valid;
  logic [31:0] cur_pc;
  exp_t        last_exp;
  int          skip_timing;
  int          bubbles;
  int          real_seen;

  // memory / reset state
  bit outstanding;
  int wait_cnt;
  int rst_cnt;
  bit prev_branch;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0001;  // never zero for word-aligned addresses
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic ds);
    exp_t e;
    e.pc   = pc;
    e.inst = mem_data(pc);
    e.ds   = ds;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: sample IF/ID after each rising edge and compare with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_id_pc", id_pc_o, 32'h0);
        check("rst_id_inst", id_inst_o, 32'h0);
        check("rst_ds", 32'(is_in_delayslot_o), 32'd0);
        cur_valid   = 1'b0;
        skip_timing = 1;
        bubbles     = 0;
        last_exp    = '0;
      end else if (!stall_id_i) begin
        if (id_inst_o == 32'h0) begin
          check("bubble_pc", id_pc_o, 32'h0);
          check("bubble_ds", 32'(is_in_delayslot_o), 32'd0);
          cur_valid = 1'b0;
          bubbles++;
          last_exp = '0;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_inst actual pc=%h required none", id_pc_o);
          cur_valid = 1'b0;
        end else begin
          e = exp_q.pop_front();
          check("id_pc", id_pc_o, e.pc);
          check("id_inst", id_inst_o, e.inst);
          check("id_ds", 32'(is_in_delayslot_o), 32'(e.ds));
          if (fixed_timing && skip_timing == 0)
            check("bubble_count", 32'(bubbles), 32'(lat_min));
          if (skip_timing > 0) skip_timing--;
          $display("INST pc=%h inst=%h ds=%0d bubbles=%0d", id_pc_o, id_inst_o, is_in_delayslot_o, bubbles);
          bubbles   = 0;
          cur_valid = 1'b1;
          cur_pc    = e.pc;
          last_exp  = e;
          real_seen++;
        end
      end else begin
        check("hold_pc", id_pc_o, last_exp.pc);
        check("hold_inst", id_inst_o, last_exp.inst);
        check("hold_ds", 32'(is_in_delayslot_o), 32'(last_exp.ds));
      end
    end
  end

  // One clock of stimulus: reset control, memory model, decode model.
  task automatic step();
    logic [31:0] t;
    @(negedge clk);
    if (rst_cnt > 0) begin
      rst = 1'b1;
      rst_cnt--;
      exp_q.delete();
      prev_branch = 1'b0;
    end else if (rst) begin
      rst = 1'b0;
      exp_q.push_back(mk(RST_PC, 1'b0));
    end
    #1;
    // memory
    if (rst) begin
      imem_ack_i  = 1'b1;
      imem_data_i = $urandom;
      outstanding = 1'b0;
    end else if (!imem_req_o) begin
      outstanding = 1'b0;
      imem_ack_i  = 1'($urandom_range(0, 1));
      imem_data_i = $urandom;
    end else begin
      if (!outstanding) begin
        outstanding = 1'b1;
        wait_cnt    = $urandom_range(lat_min, lat_max);
      end
      if (wait_cnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_data(imem_addr_o);
        outstanding = 1'b0;
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom;
        wait_cnt--;
      end
    end
    // decode
    stall_id_i               = !rst && ($urandom_range(0, 99) < stall_pct);
    branch_flag_i            = 1'b0;
    next_inst_in_delayslot_i = 1'b0;
    branch_target_address_i  = $urandom;
    if (!rst && !stall_id_i && cur_valid) begin
      if (prev_branch) begin
        prev_branch = 1'b0;  // delay slot: its successor (the target) is already queued
      end else if ($urandom_range(0, 99) < br_pct) begin
        if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF8;
        else t = 32'($urandom_range(0, 1023)) << 2;
        exp_q.push_back(mk(cur_pc + 32'd4, 1'b1));
        exp_q.push_back(mk(t, 1'b0));
        branch_flag_i            = 1'b1;
        next_inst_in_delayslot_i = 1'b1;
        branch_target_address_i  = t;
        prev_branch              = 1'b1;
      end else begin
        exp_q.push_back(mk(cur_pc + 32'd4, 1'b0));
      end
    end else if (stall_id_i) begin
      branch_flag_i            = 1'($urandom_range(0, 1));
      next_inst_in_delayslot_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run(input int n, input int lmin, input int lmax, input int spct,
                     input int bpct, input bit fixed);
    int start;
    lat_min      = lmin;
    lat_max      = lmax;
    stall_pct    = spct;
    br_pct       = bpct;
    fixed_timing = fixed;
    skip_timing  = 2;
    start        = real_seen;
    repeat (n) step();
    check("progress", 32'(real_seen > start), 32'd1);
  endtask

  task automatic reset_mid_request();
    bit found = 1'b0;
    lat_min      = 3;
    lat_max      = 3;
    stall_pct    = 0;
    br_pct       = 0;
    fixed_timing = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      step();
      if (!rst && imem_req_o && outstanding && wait_cnt > 0) found = 1'b1;
    end
    check("reset_window_found", 32'(found), 32'd1);
    rst_cnt = 2;
    repeat (3) step();
    lat_min = 0;
    lat_max = 0;
    repeat (5) step();
    check("after_reset_progress", 32'(real_seen > 0), 32'd1);
  endtask

  initial begin
    rst                      = 1'b1;
    stall_id_i               = 1'b0;
    branch_flag_i            = 1'b0;
    branch_target_address_i  = 32'h0;
    next_inst_in_delayslot_i = 1'b0;
    imem_ack_i               = 1'b0;
    imem_data_i              = 32'h0;
    cur_valid                = 1'b0;
    cur_pc                   = 32'h0;
    last_exp                 = '0;
    skip_timing              = 1;
    bubbles                  = 0;
    real_seen                = 0;
    outstanding              = 1'b0;
    wait_cnt                 = 0;
    rst_cnt                  = 3;
    prev_branch              = 1'b0;
    lat_min                  = 0;
    lat_max                  = 0;
    stall_pct                = 0;
    br_pct                   = 0;
    fixed_timing             = 1'b0;

    run(20, 0, 0, 0, 0, 1'b1);    // zero-wait sequential stream
    run(30, 2, 2, 0, 0, 1'b1);    // two wait states: two bubbles per fetch
    run(40, 0, 0, 0, 30, 1'b1);   // branches with zero-wait memory
    run(60, 3, 3, 0, 40, 1'b1);   // branches with slow delay-slot fetch
    run(60, 0, 0, 50, 0, 1'b0);   // decode stalls against zero-wait memory
    reset_mid_request();
    run(600, 0, 3, 30, 25, 1'b0); // everything random

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
